// File: rtl/lanternfish_pkg.sv
// Shared types and saturating arithmetic for the lanternfish population simulator.
package lanternfish_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM  = 2'd2
    } state_t;

    // Returns {sat_flag, sum}; sum is clamped to 2^width-1 (width <= 63).
    function automatic logic [64:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          width);
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        if (s > lim) return {1'b1, lim[63:0]};
        return {1'b0, s[63:0]};
    endfunction

endpackage

// File: rtl/lanternfish_bucket_bank.sv
// Histogram of fish per timer value: insert path, one-day shift, debug and sum read ports.
module lanternfish_bucket_bank
    import lanternfish_pkg::*;
#(
    parameter int CYCLE     = 7,
    parameter int NEW_DELAY = 2,
    parameter int CNT_W     = 41,
    parameter int N         = 9,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             ins_en,
    input  logic [IDX_W-1:0] ins_idx,
    input  logic             step,
    input  logic [IDX_W-1:0] sum_idx,
    output logic [CNT_W-1:0] sum_count,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic             ovf_event
);

    logic [CNT_W-1:0] cnt [N];
    logic [CNT_W-1:0] nxt [N];
    logic [64:0]      parent_sat;
    logic [64:0]      ins_sat;

    // Parents reload to CYCLE-1; with no extra newborn delay that slot is just the newborns.
    generate
        if (NEW_DELAY > 0) begin : g_parent
            assign parent_sat = sat_add(64'(cnt[CYCLE]), 64'(cnt[0]), CNT_W);
        end else begin : g_noparent
            assign parent_sat = {1'b0, 64'(cnt[0])};
        end
    endgenerate

    assign ins_sat = sat_add(64'(cnt[ins_idx]), 64'd1, CNT_W);

    always_comb begin
        nxt       = cnt;
        ovf_event = 1'b0;
        if (step) begin
            for (int i = 1; i < N; i++) nxt[i-1] = cnt[i];
            nxt[N-1]     = cnt[0];
            nxt[CYCLE-1] = parent_sat[CNT_W-1:0];
            ovf_event    = parent_sat[64];
        end else if (ins_en) begin
            nxt[ins_idx] = ins_sat[CNT_W-1:0];
            ovf_event    = ins_sat[64];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            cnt <= nxt;
        end
    end

    assign sum_count = cnt[sum_idx];
    assign rd_count  = ({1'b0, rd_idx} < (IDX_W+1)'(N)) ? cnt[rd_idx] : '0;

endmodule

// File: rtl/lanternfish_sim.sv
// Population simulator top: IDLE/RUN/SUM control, day and sum counters, accumulator, sticky flags.
module lanternfish_sim
    import lanternfish_pkg::*;
#(
    parameter  int CYCLE     = 7,
    parameter  int NEW_DELAY = 2,
    parameter  int CNT_W     = 41,
    parameter  int DAYS_W    = 16,
    localparam int N         = CYCLE + NEW_DELAY,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_value,
    input  logic              run_valid,
    output logic              run_ready,
    input  logic [DAYS_W-1:0] run_days,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  total,
    output logic              overflow,
    output logic              bad_value,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CNT_W-1:0]  rd_count
);

    state_t            state, state_nxt;
    logic [DAYS_W-1:0] days_left;
    logic [IDX_W-1:0]  sum_idx;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  sum_count;
    logic [64:0]       acc_sat;
    logic              bank_ovf;
    logic              ins_fire, ins_ok, run_fire, last_day, last_bucket;

    assign ins_fire    = in_valid & in_ready;
    assign run_fire    = run_valid & run_ready;
    assign ins_ok      = ins_fire && ({1'b0, in_value} < (IDX_W+1)'(N));
    assign last_day    = (days_left == DAYS_W'(1));
    assign last_bucket = (sum_idx == IDX_W'(N-1));
    assign acc_sat     = sat_add(64'(acc), 64'(sum_count), CNT_W);

    lanternfish_bucket_bank #(
        .CYCLE(CYCLE), .NEW_DELAY(NEW_DELAY), .CNT_W(CNT_W), .N(N), .IDX_W(IDX_W)
    ) u_bank (
        .clk(clk), .reset(reset), .clear(clear),
        .ins_en(ins_ok), .ins_idx(in_value),
        .step(state == RUN),
        .sum_idx(sum_idx), .sum_count(sum_count),
        .rd_idx(rd_idx), .rd_count(rd_count),
        .ovf_event(bank_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_fire) state_nxt = (run_days == '0) ? SUM : RUN;
            RUN:     if (last_day) state_nxt = SUM;
            SUM:     if (last_bucket) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        run_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // The accumulator and sum index are held at zero until SUM so entry needs no extra setup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            days_left <= '0;
            sum_idx   <= '0;
            acc       <= '0;
            total     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bad_value <= 1'b0;
        end else if (clear) begin
            days_left <= '0;
            sum_idx   <= '0;
            acc       <= '0;
            total     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bad_value <= 1'b0;
        end else begin
            done      <= 1'b0;
            overflow  <= overflow | bank_ovf | ((state == SUM) & acc_sat[64]);
            bad_value <= bad_value | (ins_fire & ~ins_ok);
            case (state)
                IDLE: begin
                    acc     <= '0;
                    sum_idx <= '0;
                    if (run_fire) days_left <= run_days;
                end
                RUN: begin
                    acc       <= '0;
                    sum_idx   <= '0;
                    days_left <= days_left - DAYS_W'(1);
                end
                SUM: begin
                    acc     <= acc_sat[CNT_W-1:0];
                    sum_idx <= sum_idx + IDX_W'(1);
                    if (last_bucket) begin
                        total   <= acc_sat[CNT_W-1:0];
                        done    <= 1'b1;
                        sum_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lanternfish_sim.sv
// Bench for lanternfish_sim: vector table, corner-case sequences and randomized runs vs a histogram model.
module tb_lanternfish_sim;

    localparam int N = 9;
    localparam longint unsigned MAX41 = (64'd1 << 41) - 64'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_value = '0;
    logic        run_valid = 1'b0;
    logic [15:0] run_days = '0;
    logic [3:0]  rd_idx = '0;

    logic        in_ready, run_ready, busy, done, overflow, bad_value;
    logic [40:0] total, rd_count;
    logic        in_ready4, run_ready4, busy4, done4, overflow4, bad_value4;
    logic [3:0]  total4, rd_count4;

    lanternfish_sim dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .run_valid(run_valid), .run_ready(run_ready), .run_days(run_days),
        .busy(busy), .done(done), .total(total), .overflow(overflow),
        .bad_value(bad_value), .rd_idx(rd_idx), .rd_count(rd_count)
    );

    lanternfish_sim #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready4), .in_value(in_value),
        .run_valid(run_valid), .run_ready(run_ready4), .run_days(run_days),
        .busy(busy4), .done(done4), .total(total4), .overflow(overflow4),
        .bad_value(bad_value4), .rd_idx(rd_idx), .rd_count(rd_count4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint unsigned m [N];
    longint unsigned m_total;
    bit m_ovf, m_bad;

    typedef struct {
        int              days;
        longint unsigned exp_total;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint unsigned msat(input longint unsigned a, input longint unsigned b);
        longint unsigned s = a + b;
        if (s > MAX41) begin
            m_ovf = 1'b1;
            return MAX41;
        end
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i] = 0;
        m_total = 0;
        m_ovf = 0;
        m_bad = 0;
    endfunction

    function automatic void model_insert(input int v);
        if (v >= N) m_bad = 1'b1;
        else m[v] = msat(m[v], 1);
    endfunction

    // A fish at timer 0 spawns: it restarts at 6 and a newborn appears at 8.
    function automatic void model_day();
        longint unsigned z = m[0];
        for (int i = 1; i < N; i++) m[i-1] = m[i];
        m[N-1] = z;
        m[6] = msat(m[6], z);
    endfunction

    function automatic void model_sum();
        longint unsigned s = 0;
        for (int i = 0; i < N; i++) s = msat(s, m[i]);
        m_total = s;
    endfunction

    task automatic do_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; run_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic insert(input int v);
        in_valid = 1'b1;
        in_value = 4'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_insert(v);
    endtask

    task automatic insert_sample();
        insert(3); insert(4); insert(3); insert(1); insert(2);
    endtask

    task automatic run(input int d, input bit with_ins, input int v);
        longint unsigned prev = m_total;
        int lat;
        if (with_ins) begin
            in_valid = 1'b1;
            in_value = 4'(v);
            model_insert(v);
        end
        run_valid = 1'b1;
        run_days  = 16'(d);
        @(posedge clk); #1;
        run_valid = 1'b0;
        in_valid  = 1'b0;
        for (int k = 0; k < d; k++) model_day();
        model_sum();
        lat = 1;
        check("in_ready_busy", in_ready, 0);
        check("total_hold", total, prev);
        while (!done && lat < d + N + 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, d + N + 1);
        check("total", total, m_total);
        check("overflow", overflow, m_ovf);
        check("bad_value", bad_value, m_bad);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    task automatic check_buckets();
        for (int i = 0; i < N; i++) begin
            rd_idx = 4'(i);
            #1 check($sformatf("count[%0d]", i), rd_count, m[i]);
        end
        rd_idx = 4'(12);
        #1 check("rd_out_of_range", rd_count, 0);
        rd_idx = '0;
        @(posedge clk); #1;
    endtask

    vec_t vecs [4];
    int   done_seen;

    initial begin
        vecs[0] = '{days: 0,   exp_total: 5};
        vecs[1] = '{days: 18,  exp_total: 26};
        vecs[2] = '{days: 80,  exp_total: 5934};
        vecs[3] = '{days: 256, exp_total: 64'd26984457539};

        model_reset();
        reset = 1'b0;
        #2;
        check("reset_total", total, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        do_reset();
        check("reset_in_ready", in_ready, 1);
        check("reset_run_ready", run_ready, 1);

        for (int t = 0; t < 4; t++) begin
            do_reset();
            insert_sample();
            run(vecs[t].days, 1'b0, 0);
            check($sformatf("vec_total_%0d", vecs[t].days), total, vecs[t].exp_total);
            check("vec_overflow", overflow, 0);
        end

        // Consecutive runs continue from the current histogram.
        do_reset();
        insert_sample();
        run(18, 1'b0, 0);
        check("run18", total, 26);
        run(62, 1'b0, 0);
        check("run18_62", total, 5934);

        do_reset();
        insert_sample();
        run(0, 1'b0, 0);
        rd_idx = 4'd3;
        #1 check("rd3_after_run0", rd_count, 2);
        rd_idx = '0;
        check_buckets();

        // Bad insert, then insert landing in the same cycle as a one-day run.
        do_reset();
        insert(9);
        check("bad_flag", bad_value, 1);
        check_buckets();
        run(1, 1'b1, 0);
        rd_idx = 4'd6;
        #1 check("concurrent_c6", rd_count, 1);
        rd_idx = 4'd8;
        #1 check("concurrent_c8", rd_count, 1);
        rd_idx = '0;
        check_buckets();

        // Narrow counters saturate; the wide instance sees the same inserts.
        do_reset();
        for (int i = 0; i < 16; i++) insert(0);
        rd_idx = '0;
        #1 check("sat4_count0", rd_count4, 15);
        check("sat4_overflow", overflow4, 1);
        check("wide_count0", rd_count, 16);
        check("wide_overflow", overflow, 0);
        run(0, 1'b0, 0);
        check("sat4_total", total4, 15);
        check("sat4_done_cleared", done4, 0);

        // Clear in the middle of a long run aborts without done.
        do_reset();
        insert_sample();
        run_valid = 1'b1;
        run_days  = 16'd100;
        @(posedge clk); #1;
        run_valid = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
            if (k == 20) begin
                check("in_ready_midrun", in_ready, 0);
                check("busy_midrun", busy, 1);
            end
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        check("clear_busy", busy, 0);
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("clear_no_done", done_seen, 0);
        check_buckets();

        // Async reset during SUM wipes outputs without waiting for a clock.
        insert_sample();
        insert(12);
        run(0, 1'b0, 0);
        check("pre_reset_total", total, 5);
        run_valid = 1'b1;
        run_days  = '0;
        @(posedge clk); #1;
        run_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("in_sum_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async_total", total, 0);
        check("async_busy", busy, 0);
        check("async_bad", bad_value, 0);
        check("async_done", done, 0);
        rd_idx = 4'd3;
        #1 check("async_count3", rd_count, 0);
        rd_idx = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();

        for (int it = 0; it < 8; it++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 20);
            for (int j = 0; j < n; j++) insert($urandom_range(0, 10));
            run($urandom_range(0, 70), 1'b0, 0);
            check_buckets();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
